// File: rtl/out_display_pkg.sv
// Shared types and constants for the output display: FSM states, the scan
// default, the seven-segment glyph table and the double-dabble step.
package out_display_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_CONVERT = 1'b1
    } state_t;

    localparam int SCAN_DIV_DEFAULT = 4;

    // Segment order {g,f,e,d,c,b,a}, active high.
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_MINUS = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic logic [11:0] dd_step(input logic [11:0] bcd, input logic bit_in);
        logic [11:0] adj;
        adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (adj[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
        end
        return {adj[10:0], bit_in};
    endfunction

endpackage

// File: rtl/out_display_seg_decode.sv
// BCD nibble to seven-segment glyph; the one place digits map to segments.
module seg_decode
    import out_display_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0: seg = SEG_0;
                4'd1: seg = SEG_1;
                4'd2: seg = SEG_2;
                4'd3: seg = SEG_3;
                4'd4: seg = SEG_4;
                4'd5: seg = SEG_5;
                4'd6: seg = SEG_6;
                4'd7: seg = SEG_7;
                4'd8: seg = SEG_8;
                4'd9: seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/out_display.sv
// CPU output register with serial binary-to-BCD conversion and a multiplexed
// four-digit seven-segment display (sign, hundreds, tens, ones).
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | result displayed, waiting for an oi load
// ST_CONVERT | running the 8 double-dabble iterations on the new value
module out_display
    import out_display_pkg::*;
#(
    parameter int SCAN_DIV = SCAN_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       oi,
    input  logic       signed_mode,
    output logic [7:0] value,
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] digit_en
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

    state_t        state, state_n;
    logic [2:0]    iter;
    logic [7:0]    mag;
    logic [7:0]    mag_in;
    logic          neg_in;
    logic [11:0]   bcd_work;
    logic [11:0]   bcd_step;
    logic          neg_work;
    logic [11:0]   bcd_disp;
    logic          neg_disp;

    logic [PW-1:0] pre, pre_n;
    logic          pre_wrap;
    logic [1:0]    idx, idx_n;
    logic [3:0]    dec_bcd;
    logic          dec_blank;
    logic [6:0]    dec_seg;
    logic [6:0]    seg_n;

    assign neg_in   = signed_mode & data[7];
    assign mag_in   = neg_in ? (~data + 8'd1) : data;
    assign bcd_step = dd_step(bcd_work, mag[7]);
    assign busy     = (state == ST_CONVERT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:    if (oi) state_n = ST_CONVERT;
            ST_CONVERT: if (!oi && iter == 3'd7) state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase
    end

    // A load always restarts from a clean scratch, so an aborted conversion
    // can never reach bcd_disp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value    <= '0;
            mag      <= '0;
            neg_work <= 1'b0;
            bcd_work <= '0;
            iter     <= '0;
            bcd_disp <= '0;
            neg_disp <= 1'b0;
        end else if (oi) begin
            value    <= data;
            mag      <= mag_in;
            neg_work <= neg_in;
            bcd_work <= '0;
            iter     <= '0;
        end else if (state == ST_CONVERT) begin
            bcd_work <= bcd_step;
            mag      <= {mag[6:0], 1'b0};
            iter     <= iter + 3'd1;
            if (iter == 3'd7) begin
                bcd_disp <= bcd_step;
                neg_disp <= neg_work;
            end
        end
    end

    always_comb begin
        pre_wrap = (pre == PRE_LAST);
        pre_n    = pre_wrap ? '0 : pre + PW'(1);
        idx_n    = pre_wrap ? idx + 2'd1 : idx;
    end

    always_comb begin
        dec_bcd   = bcd_disp[3:0];
        dec_blank = 1'b0;
        case (idx_n)
            2'd1: begin
                dec_bcd   = bcd_disp[7:4];
                dec_blank = (bcd_disp[11:4] == 8'd0);
            end
            2'd2: begin
                dec_bcd   = bcd_disp[11:8];
                dec_blank = (bcd_disp[11:8] == 4'd0);
            end
            2'd3: dec_blank = 1'b1;
            default: ;
        endcase
    end

    seg_decode u_seg_decode (
        .bcd   (dec_bcd),
        .blank (dec_blank),
        .seg   (dec_seg)
    );

    assign seg_n = (idx_n == 2'd3) ? (neg_disp ? SEG_MINUS : SEG_BLANK) : dec_seg;

    // seg is built from the upcoming index so it lands with its digit_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre      <= '0;
            idx      <= '0;
            digit_en <= 4'b0001;
            seg      <= SEG_0;
        end else begin
            pre      <= pre_n;
            idx      <= idx_n;
            digit_en <= 4'b0001 << idx_n;
            seg      <= seg_n;
        end
    end

endmodule

// File: tb/tb_out_display.sv
// Directed bench for out_display: reset, scan, unsigned/signed conversion,
// reload abort and reset abort, with hand-computed displays.
module tb_out_display;

    localparam logic [6:0] S0 = 7'h3F, S1 = 7'h06, S2 = 7'h5B, S4 = 7'h66,
                           S5 = 7'h6D, S8 = 7'h7F, S9 = 7'h6F, MN = 7'h40, BL = 7'h00;
    // Display packed as {sign, hundreds, tens, ones}.
    localparam logic [27:0] RESET_DISP = {BL, BL, BL, S0};

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       oi;
    logic       signed_mode;
    logic [7:0] value;
    logic       busy;
    logic [6:0] seg;
    logic [3:0] digit_en;

    int n_vec = 0;
    int n_err = 0;
    logic [27:0] cur_disp;

    out_display #(.SCAN_DIV(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .data        (data),
        .oi          (oi),
        .signed_mode (signed_mode),
        .value       (value),
        .busy        (busy),
        .seg         (seg),
        .digit_en    (digit_en)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] exp_seg(input logic [27:0] d, input logic [3:0] en);
        case (en)
            4'b0001: return d[6:0];
            4'b0010: return d[13:7];
            4'b0100: return d[20:14];
            4'b1000: return d[27:21];
            default: return 7'bx;
        endcase
    endfunction

    // Call at a negedge; returns at the negedge right after the load edge.
    task automatic pulse_oi(input logic [7:0] d, input logic sm);
        data        = d;
        signed_mode = sm;
        oi          = 1'b1;
        @(negedge clk);
        oi          = 1'b0;
    endtask

    task automatic capture_display(output logic [27:0] d);
        d = 'x;
        repeat (16) begin
            @(negedge clk);
            case (digit_en)
                4'b0001: d[6:0]   = seg;
                4'b0010: d[13:7]  = seg;
                4'b0100: d[20:14] = seg;
                4'b1000: d[27:21] = seg;
                default: ;
            endcase
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_vec++; if (value !== 8'h00) begin n_err++; $display("FAIL reset_value got %h want 00", value); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (digit_en !== 4'b0001) begin n_err++; $display("FAIL reset_digit_en got %b want 0001", digit_en); end
        n_vec++; if (seg !== S0) begin n_err++; $display("FAIL reset_seg got %b want %b", seg, S0); end
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (digit_en !== 4'b0001) begin n_err++; $display("FAIL post_reset_digit_en got %b want 0001", digit_en); end
        n_vec++; if (seg !== S0) begin n_err++; $display("FAIL post_reset_seg got %b want %b", seg, S0); end
    endtask

    task automatic test_scan();
        logic [3:0] e;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            e = 4'b0001 << ((k / 4) % 4);
            n_vec++; if (digit_en !== e) begin n_err++; $display("FAIL scan_digit_en k=%0d got %b want %b", k, digit_en, e); end
            n_vec++; if (seg !== exp_seg(RESET_DISP, e)) begin n_err++; $display("FAIL scan_seg k=%0d got %b want %b", k, seg, exp_seg(RESET_DISP, e)); end
            @(negedge clk);
        end
        cur_disp = RESET_DISP;
    endtask

    task automatic test_unsigned();
        logic [27:0] nd;
        nd = {BL, S2, S5, S5};
        pulse_oi(8'hFF, 1'b0);
        n_vec++; if (value !== 8'hFF) begin n_err++; $display("FAIL unsigned_value got %h want ff", value); end
        for (int k = 0; k < 12; k++) begin
            n_vec++; if (busy !== (k <= 7)) begin n_err++; $display("FAIL unsigned_busy k=%0d got %b want %b", k, busy, (k <= 7)); end
            n_vec++; if (seg !== exp_seg((k <= 8) ? cur_disp : nd, digit_en)) begin
                n_err++; $display("FAIL unsigned_seg k=%0d en=%b got %b want %b", k, digit_en, seg, exp_seg((k <= 8) ? cur_disp : nd, digit_en));
            end
            @(negedge clk);
        end
        capture_display(cur_disp);
        n_vec++; if (cur_disp !== nd) begin n_err++; $display("FAIL unsigned_display got %h want %h", cur_disp, nd); end
    endtask

    task automatic test_signed();
        logic [7:0]  vd [5];
        logic        vs [5];
        logic [27:0] ve [5];
        vd[0] = 8'h80; vs[0] = 1'b1; ve[0] = {MN, S1, S2, S8};
        vd[1] = 8'h80; vs[1] = 1'b0; ve[1] = {BL, S1, S2, S8};
        vd[2] = 8'h64; vs[2] = 1'b1; ve[2] = {BL, S1, S0, S0};
        vd[3] = 8'h00; vs[3] = 1'b1; ve[3] = {BL, BL, BL, S0};
        vd[4] = 8'hFF; vs[4] = 1'b1; ve[4] = {MN, BL, BL, S1};
        for (int i = 0; i < 5; i++) begin
            pulse_oi(vd[i], vs[i]);
            n_vec++; if (value !== vd[i]) begin n_err++; $display("FAIL signed_value i=%0d got %h want %h", i, value, vd[i]); end
            repeat (9) @(negedge clk);
            capture_display(cur_disp);
            n_vec++; if (cur_disp !== ve[i]) begin n_err++; $display("FAIL signed_display i=%0d got %h want %h", i, cur_disp, ve[i]); end
        end
    endtask

    task automatic test_abort();
        logic [27:0] nd;
        nd = {BL, BL, S4, S2};
        pulse_oi(8'h07, 1'b0);
        for (int k = 0; k < 4; k++) begin
            n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL abort_first_busy k=%0d got %b want 1", k, busy); end
            n_vec++; if (seg !== exp_seg(cur_disp, digit_en)) begin n_err++; $display("FAIL abort_first_seg k=%0d got %b want %b", k, seg, exp_seg(cur_disp, digit_en)); end
            if (k < 3) @(negedge clk);
        end
        pulse_oi(8'h2A, 1'b0);
        n_vec++; if (value !== 8'h2A) begin n_err++; $display("FAIL abort_value got %h want 2a", value); end
        for (int k = 0; k < 12; k++) begin
            n_vec++; if (busy !== (k <= 7)) begin n_err++; $display("FAIL abort_busy k=%0d got %b want %b", k, busy, (k <= 7)); end
            n_vec++; if (seg !== exp_seg((k <= 8) ? cur_disp : nd, digit_en)) begin
                n_err++; $display("FAIL abort_seg k=%0d en=%b got %b want %b", k, digit_en, seg, exp_seg((k <= 8) ? cur_disp : nd, digit_en));
            end
            @(negedge clk);
        end
        capture_display(cur_disp);
        n_vec++; if (cur_disp !== nd) begin n_err++; $display("FAIL abort_display got %h want %h", cur_disp, nd); end
    endtask

    task automatic test_reset_abort();
        pulse_oi(8'h05, 1'b0);
        repeat (9) @(negedge clk);
        capture_display(cur_disp);
        n_vec++; if (cur_disp !== {BL, BL, BL, S5}) begin n_err++; $display("FAIL rstab_pre_display got %h want %h", cur_disp, {BL, BL, BL, S5}); end
        pulse_oi(8'h63, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_vec++; if (value !== 8'h00) begin n_err++; $display("FAIL rstab_value got %h want 00", value); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstab_busy got %b want 0", busy); end
        n_vec++; if (digit_en !== 4'b0001) begin n_err++; $display("FAIL rstab_digit_en got %b want 0001", digit_en); end
        n_vec++; if (seg !== S0) begin n_err++; $display("FAIL rstab_seg got %b want %b", seg, S0); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstab_after_busy k=%0d got %b want 0", k, busy); end
            n_vec++; if (seg !== exp_seg(RESET_DISP, digit_en)) begin
                n_err++; $display("FAIL rstab_after_seg k=%0d en=%b got %b want %b", k, digit_en, seg, exp_seg(RESET_DISP, digit_en));
            end
        end
        n_vec++; if (seg === S9) begin n_err++; $display("FAIL rstab_no_nine got %b want not %b", seg, S9); end
    endtask

    initial begin
        rst         = 1'b1;
        oi          = 1'b0;
        data        = 8'h00;
        signed_mode = 1'b0;
        cur_disp    = RESET_DISP;
        test_reset();
        test_scan();
        test_unsigned();
        test_signed();
        test_abort();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/out_display.md
OUT_DISPLAY -- requirements
Module: out_display

Interface
REQ-001 Parameter SCAN_DIV, default 4, clk cycles each digit stays enabled before the scan advances (SHALL be >= 1).
REQ-002 clk  input  1  system clock (the gated CPU clock); all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 data  input  8  shared CPU bus, sampled only when oi is high.
REQ-005 oi  input  1  output-register load strobe from control logic.
REQ-006 signed_mode  input  1  1 = interpret value as two's complement.
REQ-007 value  output  8  held output-register contents.
REQ-008 busy  output  1  high while binary-to-BCD conversion runs.
REQ-009 seg  output  7  active-high segments, order {g,f,e,d,c,b,a}, all-zero = blank.
REQ-010 digit_en  output  4  one-hot active-high digit select; bit0 = ones, bit1 = tens, bit2 = hundreds, bit3 = sign.

Function
REQ-011 On a clk edge with oi=1, value SHALL load data, state SHALL enter CONVERT, and busy SHALL be high from the next cycle.
REQ-012 FSM states SHALL be IDLE and CONVERT: IDLE->CONVERT on oi; CONVERT runs exactly 8 iterations, then returns to IDLE.
REQ-013 Each CONVERT cycle SHALL perform one double-dabble step (add 3 to any BCD nibble >= 5, then shift the magnitude MSB in); 12-bit BCD scratch, 3-bit iteration counter.
REQ-014 Conversion magnitude SHALL be value when signed_mode=0 or value[7]=0; otherwise it SHALL be the 8-bit two's-complement negation, so -128 gives magnitude 128.
REQ-015 signed_mode and the negative flag SHALL be captured at the oi edge and held with the conversion.
REQ-016 Displayed BCD digits and sign SHALL update atomically on the cycle busy falls, i.e. 9 cycles after the oi edge; the previous result SHALL be displayed until then.
REQ-017 oi asserted during CONVERT SHALL reload value, discard the partial result, and restart at iteration 0; no result of the aborted conversion SHALL ever be displayed.
REQ-018 Leading-zero blanking: hundreds SHALL be blank if 0; tens SHALL be blank if hundreds and tens are both 0; ones SHALL always show.
REQ-019 Sign digit SHALL show minus (segment g only) when the captured negative flag is set, else blank.
REQ-020 Scan: a prescaler SHALL count 0..SCAN_DIV-1, and on wrap the digit index SHALL advance 0->1->2->3->0.
REQ-021 digit_en and seg SHALL be registered together so they always refer to the same digit (no ghosting cycle).
REQ-022 The scan SHALL run continuously, independent of busy and oi.

Reset
REQ-023 rst SHALL asynchronously force: value=0, busy=0, state IDLE, BCD result 0, negative flag 0, prescaler 0, digit index 0.
REQ-024 While in reset and on the first cycle after it, digit_en=0001 and seg shows "0" (0111111).
REQ-025 rst during CONVERT SHALL abort the conversion, with no update of the displayed result.

Structure
REQ-026 Package out_display_pkg SHALL hold the state enum, the SCAN_DIV default, and the segment constants (digits 0-9, MINUS, BLANK).
REQ-027 A combinational sub-module seg_decode (4-bit BCD plus blank flag -> 7-bit seg) SHALL be the only digit-to-segment mapping.

Verification
REQ-028 Reset then idle, SCAN_DIV=4 -> value=0, digit_en cycles 0001,0010,0100,1000 every 4 clks, only the ones digit shows "0".
REQ-029 oi=1, data=0xFF, signed_mode=0 -> busy high for 8 cycles; display updates 9 cycles after the oi edge to blank,"2","5","5".
REQ-030 oi=1, data=0x80, signed_mode=1 -> display shows "-","1","2","8"; data=0xFF shows "-",blank,blank,"1".
REQ-031 oi with 0x07, then oi with 0x2A at the 4th CONVERT cycle -> "7" never appears; final display is blank,blank,"4","2" 9 cycles after the second oi.
REQ-032 rst asserted mid-conversion of 0x63 after 0x05 is displayed -> outputs immediately take reset values; after release, no "99" appears until a new oi.
